// File: rtl/generador_codigo_gray.sv
// -----------------------------------------------------------------------------
// generador_codigo_gray
//
// Binary-to-Gray generator. Keeps a WIDTH-bit binary count that steps once per
// divided-clock tick and drives that count as registered Gray code. It is the
// transmit-side counterpart of the Gray-to-binary reader and feeds both the
// decoder under test and the LED/pin outputs.
//
// Optional build macro: GRAY_SATURATE_EN
//   undefined : the count wraps modulo 2^WIDTH; wrap flags max->0 / 0->max.
//   defined   : the count saturates at max (up) and 0 (down); the step still
//               ticks but leaves bin_q/gray unchanged, and wrap flags the event.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-high reset
//   en        in   level: 1 = run, 0 = hold (partial divider count discarded)
//   dir       in   1 = count up, 0 = count down (sampled only at the step edge)
//   load      in   synchronous preset strobe, priority over everything but reset
//   load_bin  in   binary preset value
//   gray      out  registered Gray code of bin_q
//   bin_q     out  registered binary count
//   tick      out  one-cycle pulse in the cycle after a step edge
//   wrap      out  one-cycle pulse coincident with tick on wrap/saturation
//   dbg_state out  FSM state (0 = S_IDLE, 1 = S_RUN)
//
// Control semantics: en and load are plain levels sampled on every rising clk
// edge; there is no handshake. tick/wrap are registered single-cycle pulses.
// -----------------------------------------------------------------------------
module generador_codigo_gray #(
  parameter int WIDTH  = 4,
  parameter int LIMITE = 24999999,
  parameter int CNT_W  = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin_q,
  output logic             tick,
  output logic             wrap,
  output logic             dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMITE_C = CNT_W'(LIMITE);
  localparam logic [WIDTH-1:0] MAX_C    = '1;
  localparam logic [WIDTH-1:0] MIN_C    = '0;

  state_t           state_q;
  logic [CNT_W-1:0] contador_q;

  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic [WIDTH-1:0] gray_load;
  logic             wrap_d;
  logic             at_limite;

  assign at_limite = (contador_q == LIMITE_C);
  assign dbg_state = state_q;

  // Value the count takes if the current edge is a step edge.
  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (dir) begin
      if (bin_q == MAX_C) begin
        wrap_d = 1'b1;
`ifdef GRAY_SATURATE_EN
        bin_d  = bin_q;
`else
        bin_d  = MIN_C;
`endif
      end else begin
        bin_d = bin_q + 1'b1;
      end
    end else begin
      if (bin_q == MIN_C) begin
        wrap_d = 1'b1;
`ifdef GRAY_SATURATE_EN
        bin_d  = bin_q;
`else
        bin_d  = MAX_C;
`endif
      end else begin
        bin_d = bin_q - 1'b1;
      end
    end
  end

  // Gray is encoded from the next binary value so gray and bin_q update on the
  // same edge and never disagree.
  assign gray_d    = bin_d ^ (bin_d >> 1);
  assign gray_load = load_bin ^ (load_bin >> 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      contador_q <= '0;
      bin_q      <= '0;
      gray       <= '0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else if (load) begin
      // Preset restarts the divider period; a step due on this edge is lost.
      bin_q      <= load_bin;
      gray       <= gray_load;
      contador_q <= '0;
      tick       <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          contador_q <= '0;
          tick       <= 1'b0;
          wrap       <= 1'b0;
          if (en) state_q <= S_RUN;
        end
        S_RUN: begin
          if (!en) begin
            // Dropping en discards the partial period.
            state_q    <= S_IDLE;
            contador_q <= '0;
            tick       <= 1'b0;
            wrap       <= 1'b0;
          end else if (at_limite) begin
            contador_q <= '0;
            bin_q      <= bin_d;
            gray       <= gray_d;
            tick       <= 1'b1;
            wrap       <= wrap_d;
          end else begin
            contador_q <= contador_q + 1'b1;
            tick       <= 1'b0;
            wrap       <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          contador_q <= '0;
          tick       <= 1'b0;
          wrap       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_generador_codigo_gray.sv
module tb_generador_codigo_gray;

  localparam int W   = 4;
  localparam int LIM = 3;
  localparam int CW  = 4;
  localparam int EW  = 2 * W + 1;

`ifdef GRAY_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] gray;
  logic [W-1:0] bin_q;
  logic         tick;
  logic         wrap;
  logic         dbg_state;

  generador_codigo_gray #(
    .WIDTH (W),
    .LIMITE(LIM),
    .CNT_W (CW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .load     (load),
    .load_bin (load_bin),
    .gray     (gray),
    .bin_q    (bin_q),
    .tick     (tick),
    .wrap     (wrap),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: {wrap, bin, gray} expected at each tick
  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  mb;
  logic [W-1:0]  prev_gray;
  int            total  = 0;
  int            passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reference next count: returns {wrap, next_bin}.
  function automatic logic [W:0] nxt(input logic [W-1:0] b, input logic up);
    logic [W-1:0] maxv;
    logic [W-1:0] minv;
    maxv = '1;
    minv = '0;
    if (up) begin
      if (b == maxv) return SAT ? {1'b1, b} : {1'b1, minv};
      return {1'b0, b + 1'b1};
    end
    if (b == minv) return SAT ? {1'b1, b} : {1'b1, maxv};
    return {1'b0, b - 1'b1};
  endfunction

  // Monitor: every tick pops one expected step.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!reset && tick) begin
      chk("tick_has_expect", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("step_gray", gray, e[W-1:0]);
        chk("step_bin", bin_q, e[2*W-1:W]);
        chk("step_wrap", wrap, e[2*W]);
        if (!(SAT && e[2*W])) chk("gray_one_bit", $countones(gray ^ prev_gray), 1);
      end
    end
    prev_gray = gray;
  end

  // One divider period (LIM+1 cycles) ending in a step; dir set to 'up' at
  // cycle flip_at of the period.
  task automatic run_period(input logic up, input int flip_at);
    logic [W:0] r;
    r  = nxt(mb, up);
    mb = r[W-1:0];
    exp_q.push_back({r[W], mb, g(mb)});
    for (int i = 0; i <= LIM; i++) begin
      if (i == flip_at) dir = up;
      @(negedge clk);
      if (i == LIM) chk("tick_step", tick, 1);
      else chk("tick_quiet", tick, 0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; dir = 1'b1; load = 1'b0; load_bin = '0;
    prev_gray = '0;
    mb = '0;
    repeat (2) @(negedge clk);
    chk("rst_gray", gray, 0);
    chk("rst_bin", bin_q, 0);
    chk("rst_tick", tick, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_state", dbg_state, 0);

    reset = 1'b0;
    @(negedge clk);
    chk("idle_hold_state", dbg_state, 0);
    chk("idle_hold_tick", tick, 0);

    // free-run up through the full range and across the wrap
    en = 1'b1;
    @(negedge clk);
    chk("enter_run", dbg_state, 1);
    chk("enter_tick", tick, 0);
    for (int k = 0; k < 16; k++) run_period(1'b1, 0);

    // down, with dir changed mid-period, across the low boundary
    run_period(1'b0, 2);
    run_period(1'b0, 0);
    run_period(1'b0, 0);
    run_period(1'b1, 1);

    // load mid-period
    repeat (2) begin @(negedge clk); chk("pre_load_tick", tick, 0); end
    load = 1'b1; load_bin = 4'b1010;
    @(negedge clk);
    load = 1'b0;
    chk("load_gray", gray, 4'b1111);
    chk("load_bin", bin_q, 4'b1010);
    chk("load_tick", tick, 0);
    chk("load_wrap", wrap, 0);
    mb = 4'b1010;
    run_period(1'b1, 0);

    // load held high, starting on the step edge: step suppressed, no ticks
    repeat (LIM) begin @(negedge clk); chk("pre_hold_tick", tick, 0); end
    load = 1'b1; load_bin = 4'b0011;
    repeat (6) begin
      @(negedge clk);
      chk("hold_gray", gray, 4'b0010);
      chk("hold_tick", tick, 0);
    end
    load = 1'b0;
    chk("hold_state", dbg_state, 1);
    mb = 4'b0011;
    run_period(1'b1, 0);

    // en dropped after two divider cycles: partial count discarded
    repeat (2) begin @(negedge clk); chk("pre_drop_tick", tick, 0); end
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("drop_state", dbg_state, 0);
      chk("drop_tick", tick, 0);
    end
    en = 1'b1;
    @(negedge clk);
    chk("reenter_run", dbg_state, 1);
    chk("reenter_tick", tick, 0);
    run_period(1'b1, 0);

    // asynchronous reset while running at bin 0111 with tick high
    load = 1'b1; load_bin = 4'b0110;
    @(negedge clk);
    load = 1'b0;
    mb = 4'b0110;
    run_period(1'b1, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_gray", gray, 0);
    chk("async_bin", bin_q, 0);
    chk("async_tick", tick, 0);
    chk("async_wrap", wrap, 0);
    chk("async_state", dbg_state, 0);
    @(negedge clk);
    reset = 1'b0;
    mb = '0;
    @(negedge clk);
    chk("post_rst_run", dbg_state, 1);
    chk("post_rst_tick", tick, 0);
    run_period(1'b1, 0);

    @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
